// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the multiplier/divider datapath.
// Width defaults, divider FSM states and two's-complement helpers.
package arith_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int VW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } div_state_e;

    // Helpers work on a 32-bit container.
    // Callers sign-extend into it and cast the result back to their width.
    function automatic logic [31:0] twos_neg(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [31:0] twos_abs(input logic [31:0] x);
        return x[31] ? twos_neg(x) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
// Ports: rem_i/bit_i/dvs_i in; rem_o (new partial remainder), qbit_o out.
module div_step
    import arith_pkg::*;
#(
    parameter int VW = VW_DEFAULT
) (
    input  logic [VW:0]   rem_i,
    input  logic          bit_i,
    input  logic [VW-1:0] dvs_i,
    output logic [VW:0]   rem_o,
    output logic          qbit_o
);

    logic [VW:0]   shifted;
    logic [VW+1:0] diff;

    // The incoming remainder is always below |divisor| <= 2^(VW-1),
    // so its top bit is zero and dropping it in the shift loses nothing.
    assign shifted = {rem_i[VW-1:0], bit_i};
    assign diff    = {1'b0, shifted} - {2'b00, dvs_i};

    always_comb begin
        rem_o  = shifted;
        qbit_o = 1'b0;
        if (!diff[VW+1]) begin
            rem_o  = diff[VW:0];
            qbit_o = 1'b1;
        end
    end

endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider, one quotient bit per clock (restoring).
// Ports: clk, reset (sync, high), start, dividend, divisor in;
//        quotient, remainder, busy, done, div_by_zero, overflow out.
module signed_divider
    import arith_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int VW = VW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero,
    output logic          overflow
);

    localparam int CW = $clog2(DW);

    div_state_e    state_q, state_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW:0]   rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sgnq_q, sgnq_d;
    logic          sgnr_q, sgnr_d;
    logic          ovfp_q, ovfp_d;
    logic          dzp_q, dzp_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] remo_q, remo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [DW-1:0] dvd_abs;
    logic [VW-1:0] dvs_abs;
    logic [DW-1:0] quo_neg;
    logic [VW-1:0] rem_neg;
    logic [VW:0]   step_rem;
    logic          step_q;
    logic          is_ovf;

    // -128 becomes unsigned 128, which still fits VW bits.
    assign dvd_abs = DW'(twos_abs(32'(signed'(dividend))));
    assign dvs_abs = VW'(twos_abs(32'(signed'(divisor))));
    assign quo_neg = DW'(twos_neg(32'(dvd_q)));
    assign rem_neg = VW'(twos_neg(32'(rem_q[VW-1:0])));

    assign is_ovf = (dividend == {1'b1, {(DW-1){1'b0}}})
                 && (divisor == '1);

    div_step #(.VW(VW)) u_step (
        .rem_i  (rem_q),
        .bit_i  (dvd_q[DW-1]),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .qbit_o (step_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            ovfp_q  <= 1'b0;
            dzp_q   <= 1'b0;
            quo_q   <= '0;
            remo_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            ovfp_q  <= ovfp_d;
            dzp_q   <= dzp_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
        ovfp_d  = ovfp_q;
        dzp_d   = 1'b0;
        quo_d   = quo_q;
        remo_d  = remo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        // Divide-by-zero answers one cycle after its start, from IDLE.
        if (dzp_q) begin
            done_d = 1'b1;
            dbz_d  = 1'b1;
            ovf_d  = 1'b0;
            quo_d  = '0;
            remo_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        dzp_d = 1'b1;
                    end else begin
                        dvd_d   = dvd_abs;
                        dvs_d   = dvs_abs;
                        rem_d   = '0;
                        cnt_d   = '0;
                        sgnq_d  = dividend[DW-1] ^ divisor[VW-1];
                        sgnr_d  = dividend[DW-1];
                        ovfp_d  = is_ovf;
                        busy_d  = 1'b1;
                        state_d = DIV;
                        if (!dzp_q) begin
                            dbz_d = 1'b0;
                            ovf_d = 1'b0;
                        end
                    end
                end
            end
            DIV: begin
                // Dividend register doubles as the quotient shift register.
                dvd_d = {dvd_q[DW-2:0], step_q};
                rem_d = step_rem;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quo_d   = sgnq_q ? quo_neg : dvd_q;
                remo_d  = sgnr_q ? rem_neg : rem_q[VW-1:0];
                ovf_d   = ovfp_q;
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign quotient    = quo_q;
    assign remainder   = remo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
